// File: rtl/alu_cmd_sequencer.sv
// Command front-end for a combinational 32-bit ALU: a small command FIFO feeds the ALU
// and the result is registered into a single response slot with divide-by-zero protection.
module alu_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_opcode,
   input  logic [31:0]      cmd_a,
   input  logic [31:0]      cmd_b,
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [3:0]       alu_opcode,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   input  logic [31:0]      alu_result,
   input  logic             alu_flagc,
   input  logic             alu_flagz,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_flagc,
   output logic             rsp_flagz,
   output logic             rsp_divz,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_DIV = 4'd3;

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
   // valid never depends on ready, and cmd_ready depends only on registered state.

   logic [3:0]       op_mem_q  [DEPTH];
   logic [31:0]      a_mem_q   [DEPTH];
   logic [31:0]      b_mem_q   [DEPTH];
   logic [TAG_W-1:0] tag_mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_result_q, rsp_result_d;
   logic             rsp_flagc_q, rsp_flagc_d;
   logic             rsp_flagz_q, rsp_flagz_d;
   logic             rsp_divz_q, rsp_divz_d;
   logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

   logic             fifo_empty;
   logic             fifo_full;
   logic             push;
   logic             pop;
   logic             slot_free;
   logic [3:0]       head_op;
   logic [31:0]      head_a;
   logic [31:0]      head_b;
   logic [TAG_W-1:0] head_tag;
   logic             head_divz;
   logic             head_addsub;

   always_comb begin
      fifo_empty  = (count_q == '0);
      fifo_full   = (count_q == CNT_W'(DEPTH));
      push        = cmd_valid && !fifo_full;
      slot_free   = !rsp_valid_q || rsp_ready;
      pop         = !fifo_empty && slot_free;
      head_op     = op_mem_q[rd_ptr_q];
      head_a      = a_mem_q[rd_ptr_q];
      head_b      = b_mem_q[rd_ptr_q];
      head_tag    = tag_mem_q[rd_ptr_q];
      head_divz   = (head_op == OP_DIV) && (head_b == 32'd0);
      head_addsub = (head_op == OP_ADD) || (head_op == OP_SUB);
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_flagc_d  = rsp_flagc_q;
      rsp_flagz_d  = rsp_flagz_q;
      rsp_divz_d   = rsp_divz_q;
      rsp_tag_d    = rsp_tag_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (pop) begin
         rsp_valid_d  = 1'b1;
         rsp_tag_d    = head_tag;
         rsp_divz_d   = head_divz;
         rsp_result_d = head_divz ? 32'd0 : alu_result;
         rsp_flagz_d  = head_divz ? 1'b1 : alu_flagz;
         // The ALU carry output is meaningless outside ADD/SUB, so it is forced low.
         rsp_flagc_d  = head_addsub ? alu_flagc : 1'b0;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= '0;
         rsp_flagc_q  <= 1'b0;
         rsp_flagz_q  <= 1'b0;
         rsp_divz_q   <= 1'b0;
         rsp_tag_q    <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_flagc_q  <= rsp_flagc_d;
         rsp_flagz_q  <= rsp_flagz_d;
         rsp_divz_q   <= rsp_divz_d;
         rsp_tag_q    <= rsp_tag_d;
      end
   end

   // Storage contents need no reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         op_mem_q[wr_ptr_q]  <= cmd_opcode;
         a_mem_q[wr_ptr_q]   <= cmd_a;
         b_mem_q[wr_ptr_q]   <= cmd_b;
         tag_mem_q[wr_ptr_q] <= cmd_tag;
      end
   end

   assign cmd_ready  = !fifo_full;
   assign alu_opcode = fifo_empty ? 4'd0  : head_op;
   assign alu_a      = fifo_empty ? 32'd0 : head_a;
   assign alu_b      = fifo_empty ? 32'd0 : head_b;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_flagc  = rsp_flagc_q;
   assign rsp_flagz  = rsp_flagz_q;
   assign rsp_divz   = rsp_divz_q;
   assign rsp_tag    = rsp_tag_q;
   assign busy       = !fifo_empty || rsp_valid_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU model on the alu_* side.
module tb_alu_cmd_sequencer;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [3:0]       cmd_opcode = '0;
   logic [31:0]      cmd_a = '0;
   logic [31:0]      cmd_b = '0;
   logic [TAG_W-1:0] cmd_tag = '0;
   logic [3:0]       alu_opcode;
   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   logic [31:0]      alu_result;
   logic             alu_flagc;
   logic             alu_flagz;
   logic             rsp_valid;
   logic             rsp_ready = 1'b1;
   logic [31:0]      rsp_result;
   logic             rsp_flagc;
   logic             rsp_flagz;
   logic             rsp_divz;
   logic [TAG_W-1:0] rsp_tag;
   logic             busy;

   int n_checks = 0;
   int n_pass   = 0;
   logic [TAG_W-1:0] exp_q[$];

   alu_cmd_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .alu_flagc(alu_flagc), .alu_flagz(alu_flagz),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flagc(rsp_flagc), .rsp_flagz(rsp_flagz), .rsp_divz(rsp_divz),
      .rsp_tag(rsp_tag), .busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ALU model; carry is deliberately 1 outside ADD/SUB and DIV-by-0 returns junk.
   always_comb begin
      logic [32:0] wide;
      wide       = '0;
      alu_result = '0;
      alu_flagc  = 1'b1;
      case (alu_opcode)
         4'd0: begin wide = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = wide[31:0]; alu_flagc = wide[32]; end
         4'd1: begin alu_result = alu_a - alu_b; alu_flagc = (alu_a < alu_b); end
         4'd2: alu_result = alu_a * alu_b;
         4'd3: alu_result = (alu_b == 32'd0) ? 32'hDEAD_BEEF : alu_a / alu_b;
         4'd4: alu_result = alu_a & alu_b;
         4'd5: alu_result = alu_a | alu_b;
         4'd8: alu_result = alu_a ^ alu_b;
         default: alu_result = alu_a;
      endcase
      alu_flagz = (alu_result == 32'd0);
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
      else n_pass++;
   endtask

   // One command with rsp_ready=1; expected response values supplied by caller.
   task automatic run_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input logic [31:0] exp_res,
                          input logic exp_c, input logic exp_z, input logic exp_dz);
      @(negedge clk);
      cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
      check("cmd_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("queued_rsp_valid", 32'(rsp_valid), 32'd0);
      check("queued_busy", 32'(busy), 32'd1);
      check("alu_opcode", 32'(alu_opcode), 32'(op));
      check("alu_a", alu_a, a);
      check("alu_b", alu_b, b);
      @(negedge clk);
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_result", rsp_result, exp_res);
      check("rsp_flagc", 32'(rsp_flagc), 32'(exp_c));
      check("rsp_flagz", 32'(rsp_flagz), 32'(exp_z));
      check("rsp_divz", 32'(rsp_divz), 32'(exp_dz));
      check("rsp_tag", 32'(rsp_tag), 32'(tag));
      @(negedge clk);
      check("drain_rsp_valid", 32'(rsp_valid), 32'd0);
      check("drain_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      logic clear_cmd;
      logic [TAG_W-1:0] exp_tag;
      clear_cmd = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_result", rsp_result, 32'd0);
      check("rst_rsp_tag", 32'(rsp_tag), 32'd0);
      check("rst_alu_a", alu_a, 32'd0);

      // directed vectors: op, a, b, tag, result, c, z, divz
      run_cmd(4'd0, 32'd5, 32'd7, 4'd1, 32'd12, 1'b0, 1'b0, 1'b0);
      run_cmd(4'd1, 32'd3, 32'd3, 4'd2, 32'd0, 1'b0, 1'b1, 1'b0);
      run_cmd(4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 4'd3, 32'hF0F0_0000, 1'b0, 1'b0, 1'b0);
      run_cmd(4'd3, 32'd10, 32'd0, 4'd7, 32'd0, 1'b0, 1'b1, 1'b1);
      run_cmd(4'd3, 32'd10, 32'd3, 4'd8, 32'd3, 1'b0, 1'b0, 1'b0);
      run_cmd(4'd0, 32'hFFFF_FFFF, 32'd1, 4'd9, 32'd0, 1'b1, 1'b1, 1'b0);
      run_cmd(4'd1, 32'd2, 32'd5, 4'd10, 32'hFFFF_FFFD, 1'b1, 1'b0, 1'b0);
      run_cmd(4'd2, 32'd6, 32'd7, 4'd11, 32'd42, 1'b0, 1'b0, 1'b0);

      // backpressure: tags 0..4 fill slot + FIFO, tag 5 must stall
      rsp_ready = 1'b0;
      for (int t = 0; t < 5; t++) begin
         @(negedge clk);
         cmd_valid = 1'b1; cmd_opcode = 4'd0; cmd_a = 32'(t); cmd_b = 32'd1; cmd_tag = TAG_W'(t);
         check("bp_cmd_ready", 32'(cmd_ready), 32'd1);
         exp_q.push_back(TAG_W'(t));
      end
      @(negedge clk);
      cmd_tag = TAG_W'(5); cmd_a = 32'd5;
      for (int k = 0; k < 3; k++) begin
         check("bp_full_ready", 32'(cmd_ready), 32'd0);
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
         check("bp_hold_tag", 32'(rsp_tag), 32'd0);
         check("bp_hold_result", rsp_result, 32'd1);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (clear_cmd) begin
            cmd_valid = 1'b0;
            clear_cmd = 1'b0;
         end
         check("bp_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
         exp_tag = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
         check("bp_drain_valid", 32'(rsp_valid), 32'd1);
         check("bp_order_tag", 32'(rsp_tag), 32'(exp_tag));
         check("bp_order_result", rsp_result, 32'(exp_tag) + 32'd1);
         if (cmd_valid && cmd_ready) begin
            exp_q.push_back(cmd_tag);
            clear_cmd = 1'b1;
         end
         @(negedge clk);
      end
      if (clear_cmd) cmd_valid = 1'b0;
      check("bp_done_valid", 32'(rsp_valid), 32'd0);
      check("bp_done_busy", 32'(busy), 32'd0);
      check("bp_q_empty", 32'(exp_q.size()), 32'd0);

      // reset mid-operation: 1 held in slot, 3 queued
      rsp_ready = 1'b0;
      for (int t = 1; t <= 4; t++) begin
         @(negedge clk);
         cmd_valid = 1'b1; cmd_opcode = 4'd5; cmd_a = 32'h11; cmd_b = 32'h22; cmd_tag = TAG_W'(t);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      check("pre_rst_valid", 32'(rsp_valid), 32'd1);
      check("pre_rst_busy", 32'(busy), 32'd1);
      check("pre_rst_alu_opcode", 32'(alu_opcode), 32'd5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      check("mid_rst_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_alu_opcode", 32'(alu_opcode), 32'd0);
      check("mid_rst_alu_a", alu_a, 32'd0);
      check("mid_rst_alu_b", alu_b, 32'd0);
      check("mid_rst_tag", 32'(rsp_tag), 32'd0);
      check("mid_rst_result", rsp_result, 32'd0);
      run_cmd(4'd8, 32'h0000_FF00, 32'h0F0F_0F0F, 4'd6, 32'h0F0F_F00F, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Clocked command front-end for the combinational 32-bit ALU.
- Accepts ALU commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ALU's opcode/a/b inputs from the FIFO head, samples the ALU's result and flags into a registered response slot, and returns them with the command tag over a second valid/ready handshake.
- Adds divide-by-zero protection and deterministic carry-flag handling.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, at least 2.
- TAG_W, 4, width of the command tag carried through to the response.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high when the FIFO can accept a command.
- cmd_opcode  in  4  ALU opcode (ADD=0, SUB=1, MUL=2, DIV=3, AND=4, OR=5, NAND=6, NOR=7, XOR=8, IN=9, RE=10, NOT=11, SL=12, SR=13, CW=14, CD=15).
- cmd_a  in  32  operand A.
- cmd_b  in  32  operand B.
- cmd_tag  in  TAG_W  opaque identifier returned with the response.
- alu_opcode  out  4  to the ALU opcode input.
- alu_a  out  32  to the ALU operand A input.
- alu_b  out  32  to the ALU operand B input.
- alu_result  in  32  from the ALU result output.
- alu_flagc  in  1  from the ALU carry flag output.
- alu_flagz  in  1  from the ALU zero flag output.
- rsp_valid  out  1  response slot holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  32  registered result.
- rsp_flagc  out  1  registered carry flag.
- rsp_flagz  out  1  registered zero flag.
- rsp_divz  out  1  DIV issued with b==0.
- rsp_tag  out  TAG_W  tag of the responding command.
- busy  out  1  FIFO non-empty or rsp_valid.

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO read/write pointers and count go to 0; stored FIFO contents are don't-care.
  - rsp_valid=0; rsp_result=0; rsp_flagc=0; rsp_flagz=0; rsp_divz=0; rsp_tag=0.
  - Reset takes priority over push and pop in the same cycle. Reset mid-operation discards all queued and held commands.
- Push:
  - cmd_ready = !fifo_full, a pure function of the registered count.
  - A command is accepted when cmd_valid && cmd_ready at an edge.
  - When full, push is blocked even if a pop occurs in the same cycle; there is no pass-through.
- ALU drive:
  - While the FIFO is non-empty, alu_opcode/alu_a/alu_b equal the head entry, combinationally from FIFO storage.
  - While the FIFO is empty, all three are driven to 0.
  - The ALU is purely combinational; alu_result and the flags are sampled in the same cycle they are driven.
- Capture/pop:
  - slot_free = !rsp_valid || rsp_ready.
  - At an edge where the FIFO is non-empty and slot_free: pop the head, set rsp_valid=1, and load rsp_tag = head tag.
  - rsp_result:
    - DIV with head b==0: 0.
    - Otherwise: alu_result.
  - rsp_flagz:
    - DIV with head b==0: 1.
    - Otherwise: alu_flagz.
  - rsp_flagc:
    - ADD or SUB: alu_flagc.
    - All other opcodes: 0. The ALU's flagC is unreliable outside ADD/SUB.
  - rsp_divz = 1 only for DIV with b==0.
- Drain: at an edge where rsp_valid && rsp_ready and no capture occurs, rsp_valid goes to 0. The response data registers hold their values.
- Simultaneous push and pop when not full: both occur; the count is unchanged.
- Latency and throughput:
  - A command accepted at edge N appears on the rsp_* outputs after edge N+1 at the earliest. Minimum latency is 2 edges from cmd_valid assertion.
  - Throughput is 1 command/cycle when rsp_ready=1.
- Ordering: responses are returned strictly in acceptance order.
- Capacity: a total of DEPTH+1 commands can be outstanding (DEPTH in the FIFO plus 1 in the response slot).
- Pointers: wrap modulo DEPTH; the count is DEPTH+1 states wide (log2(DEPTH)+1 bits).
- Output stability: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable.
- busy = (count != 0) || rsp_valid.

Test Plan:
- Reset, then ADD a=5 b=7 tag=1 with rsp_ready=1:
  - rsp_valid rises 2 edges after cmd_valid with rsp_result=12, rsp_flagz=0, rsp_tag=1.
  - busy=0 one edge later.
- SUB a=3 b=3 -> rsp_result=0, rsp_flagz=1, rsp_divz=0.
- AND a=0xF0F0F0F0 b=0xFFFF0000 -> rsp_result=0xF0F00000, rsp_flagc=0.
- DIV a=10 b=0 tag=7 -> rsp_result=0, rsp_flagz=1, rsp_divz=1, rsp_tag=7.
- DIV a=10 b=3 -> rsp_result=3, rsp_divz=0.
- Backpressure: hold rsp_ready=0 and offer tags 0..5 back-to-back (DEPTH=4):
  - Tags 0..4 are accepted; cmd_ready stays low while tag 5 is offered.
  - rsp_tag stays 0, stable.
  - Release rsp_ready: tags 0..5 emerge in order, one per cycle.
- Reset mid-operation: with 3 commands queued and rsp_valid=1, assert rst for 1 edge.
  - Next cycle: rsp_valid=0, busy=0, cmd_ready=1, alu_opcode/a/b=0.
  - A subsequent command completes normally.
